// File: rtl/gameboard_pkg.sv
// rtl/gameboard_pkg.sv - shared go encodings, board widths and move-input helpers
package gameboard_pkg;

  localparam int BOARD_W = 64;
  localparam int STATE_W = 6;
  localparam logic [9:0] MOVE_COUNT_MAX = 10'd1023;

  typedef enum logic [2:0] {
    GO_NONE  = 3'b000,
    GO_UP    = 3'b001,
    GO_DOWN  = 3'b010,
    GO_LEFT  = 3'b011,
    GO_RIGHT = 3'b100
  } goCode_e;

  typedef enum logic {
    READY = 1'b0,
    GAP   = 1'b1
  } moveState_e;

  // Fixed priority when several presses land in the same cycle.
  function automatic goCode_e pickMove(input logic up, input logic down,
                                       input logic left, input logic right);
    if (up)         return GO_UP;
    else if (down)  return GO_DOWN;
    else if (left)  return GO_LEFT;
    else if (right) return GO_RIGHT;
    else            return GO_NONE;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - 2-flop synchroniser, counter debounce and press-edge pulse for one button
module key_debounce #(
  parameter int DB_CYCLES = 500000
) (
  input  logic clk,
  input  logic resetn,
  input  logic btn,
  output logic press
);

  localparam int CNT_W = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             syncMeta;
  logic             syncLevel;
  logic             dbLevel;
  logic [CNT_W-1:0] dbCount;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      syncMeta  <= 1'b0;
      syncLevel <= 1'b0;
      dbLevel   <= 1'b0;
      dbCount   <= '0;
      press     <= 1'b0;
    end else begin
      syncMeta  <= btn;
      syncLevel <= syncMeta;
      press     <= 1'b0;
      if (syncLevel != dbLevel) begin
        // Flip only after a full run of mismatching cycles; press fires on rising flips.
        if (dbCount == CNT_LAST) begin
          dbLevel <= syncLevel;
          dbCount <= '0;
          press   <= syncLevel;
        end else begin
          dbCount <= dbCount + 1'b1;
        end
      end else begin
        dbCount <= '0;
      end
    end
  end

endmodule

// File: rtl/move_input_ctrl.sv
// rtl/move_input_ctrl.sv - debounced buttons to one-shot go commands with post-move gap and move counter
module move_input_ctrl
  import gameboard_pkg::*;
#(
  parameter int DB_CYCLES  = 500000,
  parameter int GAP_CYCLES = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       ifWin,
  output logic [2:0] go,
  output logic       busy,
  output logic [9:0] move_count
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES);

  logic [3:0] btnVec;
  logic [3:0] press;

  assign btnVec = {btn_right, btn_left, btn_down, btn_up};

  for (genvar i = 0; i < 4; i++) begin : g_key
    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_key (
      .clk    (clk),
      .resetn (resetn),
      .btn    (btnVec[i]),
      .press  (press[i])
    );
  end

  moveState_e       state;
  moveState_e       stateNext;
  logic [GAP_W-1:0] gapCnt;
  logic [GAP_W-1:0] gapNext;
  goCode_e          sel;
  goCode_e          goNext;
  logic             busyNext;
  logic [9:0]       countNext;

  always_comb begin
    sel       = pickMove(press[0], press[1], press[2], press[3]);
    stateNext = state;
    gapNext   = gapCnt;
    goNext    = GO_NONE;
    busyNext  = 1'b0;
    countNext = move_count;
    case (state)
      READY: begin
        if (!ifWin && (sel != GO_NONE)) begin
          goNext    = sel;
          stateNext = GAP;
          gapNext   = '0;
          if (move_count != MOVE_COUNT_MAX) countNext = move_count + 10'd1;
        end
      end
      GAP: begin
        // The go cycle itself is spent in GAP, followed by GAP_CYCLES busy cycles.
        if (gapCnt == GAP_LAST) begin
          stateNext = READY;
        end else begin
          gapNext  = gapCnt + 1'b1;
          busyNext = 1'b1;
        end
      end
      default: stateNext = READY;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= READY;
      gapCnt     <= '0;
      go         <= GO_NONE;
      busy       <= 1'b0;
      move_count <= '0;
    end else begin
      state      <= stateNext;
      gapCnt     <= gapNext;
      go         <= goNext;
      busy       <= busyNext;
      move_count <= countNext;
    end
  end

endmodule

// File: tb/tb_move_input_ctrl.sv
// tb/tb_move_input_ctrl.sv - randomized and directed self-checking bench for move_input_ctrl
module tb_move_input_ctrl;

  localparam int DB  = 4;
  localparam int GAP = 2;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic       ifWin = 1'b0;
  logic [2:0] go;
  logic       busy;
  logic [9:0] move_count;

  int checks = 0;
  int fails  = 0;

  move_input_ctrl #(.DB_CYCLES(DB), .GAP_CYCLES(GAP)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .ifWin      (ifWin),
    .go         (go),
    .busy       (busy),
    .move_count (move_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each edge n, a button's synchronised level is its raw value from edge n-2;
  // DB consecutive mismatching edges flip the debounced level; a rising flip is a press that
  // may issue go on the next edge if no go happened in the last GAP+1 edges and ifWin is low.
  int       edgeNum = 0;
  int       expGo = 0;
  int       expBusy = 0;
  int       expCount = 0;
  int       lastGo = -100;
  int       nextAllowed = 0;
  bit [3:0] pend, hist0, hist1, dbl;
  int       run[4];

  always @(posedge clk) begin
    logic [3:0] rawv;
    rawv = {btn_right, btn_left, btn_down, btn_up};
    edgeNum++;
    if (!resetn) begin
      expGo = 0; expBusy = 0; expCount = 0;
      lastGo = -100; nextAllowed = 0;
      pend = '0; hist0 = '0; hist1 = '0; dbl = '0;
      for (int i = 0; i < 4; i++) run[i] = 0;
    end else begin
      expGo = 0;
      if (edgeNum >= nextAllowed && !ifWin)
        for (int i = 0; i < 4; i++)
          if (pend[i] && expGo == 0) expGo = i + 1;
      if (expGo != 0) begin
        lastGo = edgeNum;
        nextAllowed = edgeNum + GAP + 2;
        if (expCount < 1023) expCount++;
      end
      expBusy = (edgeNum > lastGo && edgeNum <= lastGo + GAP) ? 1 : 0;
      for (int i = 0; i < 4; i++) begin
        pend[i] = 1'b0;
        if (hist1[i] != dbl[i]) begin
          run[i]++;
          if (run[i] == DB) begin
            dbl[i] = hist1[i];
            run[i] = 0;
            pend[i] = hist1[i];
          end
        end else begin
          run[i] = 0;
        end
        hist1[i] = hist0[i];
        hist0[i] = rawv[i];
      end
    end
  end

  int goPulses = 0;
  int lastGoVal = 0;
  int lastGoEdge = 0;

  always @(posedge clk) begin
    #2;
    check("go", int'(go), expGo);
    check("busy", int'(busy), expBusy);
    check("move_count", int'(move_count), expCount);
    if (go != 3'b000) begin
      goPulses++;
      lastGoVal = int'(go);
      lastGoEdge = edgeNum;
    end
  end

  task automatic tick;
    @(posedge clk);
    #4;
  endtask

  task automatic setBtns(input logic [3:0] v);
    btn_up = v[0]; btn_down = v[1]; btn_left = v[2]; btn_right = v[3];
  endtask

  task automatic pressUp(input int hi, input int lo);
    btn_up = 1'b1;
    repeat (hi) tick;
    btn_up = 1'b0;
    repeat (lo) tick;
  endtask

  initial begin
    int base, p0, rem[4];
    bit found;
    logic [3:0] lv;

    repeat (3) tick;
    check("reset_go", int'(go), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_count", int'(move_count), 0);
    resetn = 1'b1;
    repeat (5) tick;

    // Clean press: go at edge 7 only, busy on edges 8-9.
    btn_up = 1'b1;
    repeat (6) tick;
    check("clean_go_e6", int'(go), 0);
    tick; check("clean_go_e7", int'(go), 1);
    tick; check("clean_go_e8", int'(go), 0); check("clean_busy_e8", int'(busy), 1);
    tick; check("clean_busy_e9", int'(busy), 1);
    tick; check("clean_busy_e10", int'(busy), 0);
    check("clean_count", int'(move_count), 1);
    btn_up = 1'b0;
    repeat (20) tick;

    // Bounce on left, then stable high.
    p0 = goPulses;
    for (int i = 0; i < 10; i++) begin
      btn_left = ~btn_left;
      repeat (2) tick;
    end
    btn_left = 1'b1;
    base = edgeNum;
    repeat (20) tick;
    check("bounce_pulses", goPulses - p0, 1);
    check("bounce_code", lastGoVal, 3);
    check("bounce_latency", lastGoEdge - base, DB + 3);
    btn_left = 1'b0;
    repeat (20) tick;

    // Simultaneous down and right.
    p0 = goPulses;
    btn_down = 1'b1; btn_right = 1'b1;
    repeat (30) tick;
    check("simul_pulses", goPulses - p0, 1);
    check("simul_code", lastGoVal, 2);
    check("simul_count", int'(move_count), 3);
    setBtns(4'b0000);
    repeat (20) tick;

    // Right press lands inside GAP after an up move, then held 100 cycles.
    p0 = goPulses;
    btn_up = 1'b1;
    repeat (2) tick;
    btn_right = 1'b1;
    repeat (100) tick;
    check("gap_pulses", goPulses - p0, 1);
    check("gap_code", lastGoVal, 1);
    setBtns(4'b0000);
    repeat (20) tick;
    p0 = goPulses;
    btn_right = 1'b1;
    repeat (100) tick;
    check("hold_pulses", goPulses - p0, 1);
    check("hold_code", lastGoVal, 4);
    btn_right = 1'b0;
    repeat (20) tick;

    // Win freezes moves; no stale press after ifWin falls.
    p0 = goPulses;
    ifWin = 1'b1;
    btn_up = 1'b1;
    repeat (20) tick;
    btn_up = 1'b0;
    repeat (20) tick;
    ifWin = 1'b0;
    repeat (20) tick;
    check("win_pulses", goPulses - p0, 0);
    check("win_count", int'(move_count), 5);

    // Randomized phase.
    for (int b = 0; b < 4; b++) rem[b] = 0;
    lv = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 4; b++) begin
        if (rem[b] == 0) begin
          lv[b] = 1'($urandom_range(0, 1));
          rem[b] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 14));
        end
        rem[b]--;
      end
      setBtns(lv);
      if ($urandom_range(0, 99) == 0) ifWin = ~ifWin;
      tick;
    end
    setBtns(4'b0000);
    ifWin = 1'b0;
    repeat (20) tick;

    // Reset in the middle of a GAP with five moves counted.
    #1 resetn = 1'b0;
    tick;
    resetn = 1'b1;
    repeat (4) tick;
    repeat (4) pressUp(10, 10);
    btn_up = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick;
      if (busy) found = 1'b1;
    end
    check("mid_gap_busy_seen", int'(found), 1);
    check("mid_gap_count", int'(move_count), 5);
    #1 resetn = 1'b0;
    #1;
    check("async_go", int'(go), 0);
    check("async_busy", int'(busy), 0);
    check("async_count", int'(move_count), 0);
    btn_up = 1'b0;
    btn_down = 1'b1;
    tick; tick;

    // Button held through reset release behaves as a fresh press.
    resetn = 1'b1;
    repeat (6) tick;
    check("held_rst_go_e6", int'(go), 0);
    tick;
    check("held_rst_go_e7", int'(go), 2);
    btn_down = 1'b0;
    repeat (20) tick;

    // Saturation.
    repeat (1030) pressUp(8, 8);
    check("sat_count", int'(move_count), 1023);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
